// File: rtl/fp16_disp_pkg.sv
// Shared constants, state/code encodings and the x10 helper
// for the FP16 to decimal display decoder.
package fp16_disp_pkg;

    localparam int EXP_BIAS  = 15;
    localparam int INT_BITS  = 14;
    localparam int FRAC_BITS = 24;
    localparam int MAG_W     = INT_BITS + FRAC_BITS;

    localparam int SIGN_BIT = 15;
    localparam int EXP_HI   = 14;
    localparam int EXP_LO   = 10;
    localparam int MANT_HI  = 9;
    localparam int MANT_LO  = 0;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LOAD   = 3'd1;
    localparam state_t ST_DABBLE = 3'd2;
    localparam state_t ST_FRAC   = 3'd3;
    localparam state_t ST_DONE   = 3'd4;

    typedef enum logic [1:0] {
        CODE_NUM = 2'd0,
        CODE_INF = 2'd1,
        CODE_NAN = 2'd2,
        CODE_OVF = 2'd3
    } code_e;

    function automatic logic [FRAC_BITS+3:0] mul10(
        input logic [FRAC_BITS-1:0] f
    );
        logic [FRAC_BITS+3:0] w;
        w = {4'b0000, f};
        return (w << 3) + (w << 1);
    endfunction

endpackage

// File: rtl/fp16_display_decoder_if.sv
// Request/result bundle between the load-result logic,
// the decoder and the display mux.
interface fp16_display_decoder_if;

    logic        start;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        neg;
    logic [1:0]  code;

    modport master (
        output start, value,
        input  busy, done, digits, dp, neg, code
    );

    modport slave (
        input  start, value,
        output busy, done, digits, dp, neg, code
    );

endinterface

// File: rtl/fp16_bin2bcd_step.sv
// One double-dabble iteration: add-3 correction on each
// BCD nibble, then shift one binary bit in at the bottom.
module fp16_bin2bcd_step (
    input  logic [15:0] bcd_i,
    input  logic        bit_i,
    output logic [15:0] bcd_o
);

    logic [15:0] adj;

    always_comb begin
        adj = bcd_i;
        for (int i = 0; i < 4; i++) begin
            if (bcd_i[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_i[4*i +: 4] + 4'd3;
            end
        end
        bcd_o = (adj << 1) | {15'b0, bit_i};
    end

endmodule

// File: rtl/fp16_display_decoder.sv
// Sequential FP16 to 4-digit decimal converter: classify,
// double-dabble the integer part, then x10 fraction digits.
module fp16_display_decoder
    import fp16_disp_pkg::*;
(
    input  logic                  Clock,
    input  logic                  Reset,
    fp16_display_decoder_if.slave bus
);

    state_t         state_q, state_d;
    logic [15:0]    val_q, val_d;
    logic [13:0]    int_q, int_d;
    logic [23:0]    frac_q, frac_d;
    logic [15:0]    bcd_q, bcd_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [1:0]     rem_q, rem_d;
    logic [3:0]     dpp_q, dpp_d;
    logic           big_q, big_d;
    logic [15:0]    digits_q, digits_d;
    logic [3:0]     dp_q, dp_d;
    logic           neg_q, neg_d;
    logic [1:0]     code_q, code_d;
    logic           done_q, done_d;

    logic [4:0]       exp_f;
    logic [9:0]       mant_f;
    logic             sgn;
    logic [4:0]       exp_eff;
    logic [10:0]      sig;
    logic [MAG_W-1:0] mag;
    logic             ovf_exp;
    logic [15:0]      bcd_nx;
    logic [1:0]       rem_nx;
    logic [FRAC_BITS+3:0] prod;
    logic [15:0]      frac_w;

    assign exp_f  = val_q[EXP_HI:EXP_LO];
    assign mant_f = val_q[MANT_HI:MANT_LO];
    assign sgn    = val_q[SIGN_BIT];

    // exp=0 shares the exponent of exp=1 with a hidden 0
    assign exp_eff = (exp_f == 5'd0) ? 5'd1 : exp_f;
    assign sig     = {exp_f != 5'd0, mant_f};
    assign mag     = {{(MAG_W-11){1'b0}}, sig} << (exp_eff - 5'd1);
    assign ovf_exp = (int'(exp_f) - EXP_BIAS) >= INT_BITS;

    fp16_bin2bcd_step u_step (
        .bcd_i (bcd_q),
        .bit_i (int_q[13]),
        .bcd_o (bcd_nx)
    );

    always_comb begin
        rem_nx = 2'd3;
        if (bcd_nx[15:12] != 4'd0) begin
            rem_nx = 2'd0;
        end else if (bcd_nx[11:8] != 4'd0) begin
            rem_nx = 2'd1;
        end else if (bcd_nx[7:4] != 4'd0) begin
            rem_nx = 2'd2;
        end
    end

    assign prod   = mul10(frac_q);
    assign frac_w = {bcd_q[11:0], prod[FRAC_BITS+3:FRAC_BITS]};

    always_comb begin
        state_d  = state_q;
        val_d    = val_q;
        int_d    = int_q;
        frac_d   = frac_q;
        bcd_d    = bcd_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dpp_d    = dpp_q;
        big_d    = big_q;
        digits_d = digits_q;
        dp_d     = dp_q;
        neg_d    = neg_q;
        code_d   = code_q;
        done_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    val_d   = bus.value;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (exp_f == 5'd31) begin
                    code_d   = (mant_f != 10'd0) ? CODE_NAN : CODE_INF;
                    neg_d    = sgn & (mant_f == 10'd0);
                    digits_d = 16'h0000;
                    dp_d     = 4'b0000;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (ovf_exp) begin
                    code_d   = CODE_OVF;
                    neg_d    = sgn;
                    digits_d = 16'h0000;
                    dp_d     = 4'b0000;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    int_d   = mag[MAG_W-1:FRAC_BITS];
                    frac_d  = mag[FRAC_BITS-1:0];
                    big_d   = mag[MAG_W-1:FRAC_BITS] > 14'd9999;
                    bcd_d   = 16'h0000;
                    cnt_d   = 4'd0;
                    state_d = ST_DABBLE;
                end
            end
            ST_DABBLE: begin
                bcd_d = bcd_nx;
                int_d = {int_q[12:0], 1'b0};
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd13) begin
                    if (big_q) begin
                        code_d   = CODE_OVF;
                        neg_d    = sgn;
                        digits_d = 16'h0000;
                        dp_d     = 4'b0000;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else if (rem_nx == 2'd0) begin
                        code_d   = CODE_NUM;
                        neg_d    = sgn & (bcd_nx != 16'h0000);
                        digits_d = bcd_nx;
                        dp_d     = 4'b0001;
                        done_d   = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        rem_d   = rem_nx;
                        dpp_d   = 4'b0001 << rem_nx;
                        state_d = ST_FRAC;
                    end
                end
            end
            ST_FRAC: begin
                // shifting digits in from the right left-justifies the integer part
                bcd_d  = frac_w;
                frac_d = prod[FRAC_BITS-1:0];
                rem_d  = rem_q - 2'd1;
                if (rem_q == 2'd1) begin
                    code_d   = CODE_NUM;
                    neg_d    = sgn & (frac_w != 16'h0000);
                    digits_d = frac_w;
                    dp_d     = dpp_q;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= ST_IDLE;
            val_q    <= '0;
            int_q    <= '0;
            frac_q   <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            dpp_q    <= '0;
            big_q    <= 1'b0;
            digits_q <= '0;
            dp_q     <= '0;
            neg_q    <= 1'b0;
            code_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            val_q    <= val_d;
            int_q    <= int_d;
            frac_q   <= frac_d;
            bcd_q    <= bcd_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dpp_q    <= dpp_d;
            big_q    <= big_d;
            digits_q <= digits_d;
            dp_q     <= dp_d;
            neg_q    <= neg_d;
            code_q   <= code_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.digits = digits_q;
    assign bus.dp     = dp_q;
    assign bus.neg    = neg_q;
    assign bus.code   = code_q;

endmodule
